// File: rtl/alu_operand_collector.sv
// alu_operand_collector: accepts one decoded ALU instruction, reads its source
// registers one slot per cycle through a single synchronous RF read port, and
// presents op + operands to the ALU under valid/ready.
// Optional feature: define ALU_OC_BYPASS_EN to merge in-flight writeback data
// into collected operands (the RF itself is read-before-write).

package alu_oc_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;
endpackage

module alu_operand_collector
  import alu_oc_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NumInPort = 2,
  parameter int unsigned RegAddrW  = 5
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                req_valid_i,
  output logic                                req_ready_o,
  input  alu_op_t                             req_op_i,
  input  logic [NumInPort-1:0][RegAddrW-1:0]  req_rs_i,
  input  logic                                req_use_imm_i,
  input  logic [XLEN-1:0]                     req_imm_i,
  input  logic [RegAddrW-1:0]                 req_rd_i,
  output logic                                rf_re_o,
  output logic [RegAddrW-1:0]                 rf_raddr_o,
  input  logic [XLEN-1:0]                     rf_rdata_i,
  input  logic                                wb_valid_i,
  input  logic [RegAddrW-1:0]                 wb_addr_i,
  input  logic [XLEN-1:0]                     wb_data_i,
  output logic                                alu_valid_o,
  input  logic                                alu_ready_i,
  output alu_op_t                             alu_op_o,
  output logic [NumInPort-1:0][XLEN-1:0]      operand_o,
  output logic [RegAddrW-1:0]                 alu_rd_o
);

  localparam int unsigned KW = (NumInPort > 1) ? $clog2(NumInPort) : 1;
  localparam logic [KW-1:0] LastK = KW'(NumInPort - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_ISSUE = 2'd3
  } state_e;

  state_e                             state_q, state_d;
  logic [KW-1:0]                      k_q, k_d;
  // Previous slot issued an RF read whose data arrives this cycle.
  logic                               pend_q, pend_d;
  alu_op_t                            op_q;
  logic [NumInPort-1:0][RegAddrW-1:0] rs_q;
  logic                               use_imm_q;
  logic [XLEN-1:0]                    imm_q;
  logic [RegAddrW-1:0]                rd_q;
  logic [NumInPort-1:0][XLEN-1:0]     operand_q, operand_d;

  logic                               accept_s;
  logic                               slot_reads_s;
  logic                               req_ready_s;
  logic                               alu_valid_s;
  logic                               rf_re_s;
  logic [RegAddrW-1:0]                raddr_s;
  logic [KW-1:0]                      cap_idx_s;
  logic [NumInPort-1:0]               byp_hit_s;

  // Decide whether the current slot needs the RF (x0 and the immediate slot do not).
  always_comb begin
    slot_reads_s = (rs_q[k_q] != {RegAddrW{1'b0}}) && !(use_imm_q && (k_q == LastK));
  end

`ifdef ALU_OC_BYPASS_EN
  // Per-slot writeback match, live from the slot's read cycle through the issue handshake.
  always_comb begin
    byp_hit_s = '0;
    for (int j = 0; j < int'(NumInPort); j++) begin
      if (wb_valid_i && (wb_addr_i == rs_q[j]) && (rs_q[j] != {RegAddrW{1'b0}}) &&
          !(use_imm_q && (j == int'(NumInPort) - 1))) begin
        case (state_q)
          S_READ:           byp_hit_s[j] = (int'(k_q) >= j);
          S_DRAIN, S_ISSUE: byp_hit_s[j] = 1'b1;
          default:          byp_hit_s[j] = 1'b0;
        endcase
      end else begin
        byp_hit_s[j] = 1'b0;
      end
    end
  end
`else
  assign byp_hit_s = '0;
  logic unused_wb_s;
  assign unused_wb_s = ^{wb_valid_i, wb_addr_i, wb_data_i};
`endif

  // Next-state and control decode; every slot spends exactly one cycle in READ.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    pend_d      = pend_q;
    accept_s    = 1'b0;
    req_ready_s = 1'b0;
    alu_valid_s = 1'b0;
    rf_re_s     = 1'b0;
    raddr_s     = {RegAddrW{1'b0}};
    case (state_q)
      S_IDLE: begin
        req_ready_s = 1'b1;
        if (req_valid_i) begin
          accept_s = 1'b1;
          state_d  = S_READ;
          k_d      = {KW{1'b0}};
          pend_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        rf_re_s = slot_reads_s;
        raddr_s = slot_reads_s ? rs_q[k_q] : {RegAddrW{1'b0}};
        // A bypass in the read cycle already holds the fresh value; skip the stale RF data.
        pend_d  = slot_reads_s && !byp_hit_s[k_q];
        if (k_q == LastK) begin
          state_d = S_DRAIN;
          k_d     = {KW{1'b0}};
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DRAIN: begin
        pend_d  = 1'b0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        alu_valid_s = 1'b1;
        if (alu_ready_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand update: RF capture for the previous slot, fill for non-reading slots, bypass last.
  always_comb begin
    operand_d = operand_q;
    cap_idx_s = (state_q == S_DRAIN) ? LastK : (k_q - KW'(1));
    if (pend_q && ((state_q == S_READ) || (state_q == S_DRAIN))) begin
      operand_d[cap_idx_s] = rf_rdata_i;
    end else begin
      operand_d[cap_idx_s] = operand_q[cap_idx_s];
    end
    if ((state_q == S_READ) && !slot_reads_s) begin
      operand_d[k_q] = (use_imm_q && (k_q == LastK)) ? imm_q : {XLEN{1'b0}};
    end else begin
      operand_d[k_q] = operand_d[k_q];
    end
    for (int j = 0; j < int'(NumInPort); j++) begin
      if (byp_hit_s[j]) begin
        operand_d[j] = wb_data_i;
      end else begin
        operand_d[j] = operand_d[j];
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      k_q     <= {KW{1'b0}};
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      pend_q  <= pend_d;
    end
  end

  // Request latch and operand storage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q      <= ALU_ADD;
      rs_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= {XLEN{1'b0}};
      rd_q      <= {RegAddrW{1'b0}};
      operand_q <= '0;
    end else begin
      operand_q <= operand_d;
      if (accept_s) begin
        op_q      <= req_op_i;
        rs_q      <= req_rs_i;
        use_imm_q <= req_use_imm_i;
        imm_q     <= req_imm_i;
        rd_q      <= req_rd_i;
      end
    end
  end

  // Handshake and RF strobes are forced low for the whole time reset is held.
  assign req_ready_o = req_ready_s & ~rst_i;
  assign alu_valid_o = alu_valid_s & ~rst_i;
  assign rf_re_o     = rf_re_s & ~rst_i;
  assign rf_raddr_o  = rst_i ? {RegAddrW{1'b0}} : raddr_s;
  assign alu_op_o    = op_q;
  assign operand_o   = operand_q;
  assign alu_rd_o    = rd_q;

endmodule

// File: doc/alu_operand_collector.md
# alu_operand_collector

Front end for the `alu`. Accepts one decoded ALU instruction at a time and reads its source registers serially through a single synchronous register-file read port. Optionally merges in-flight writeback data, then presents the op and a full `operand` vector to the ALU under a valid/ready handshake. Sits between issue/decode and the ALU in the core pipeline.

## Interface
- `XLEN`, 32, datapath width
- `NumInPort`, 2, operands per instruction; matches the ALU `operand_i` vector
- `RegAddrW`, 5, register index width

- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `req_valid_i`  in  1  instruction offered
- `req_ready_o`  out  1  collector can accept
- `req_op_i`  in  `alu_op_t`  ALU operation
- `req_rs_i`  in  `[NumInPort-1:0][RegAddrW-1:0]`  source register indices
- `req_use_imm_i`  in  1  operand `NumInPort-1` taken from `req_imm_i`, not the RF
- `req_imm_i`  in  XLEN  immediate
- `req_rd_i`  in  RegAddrW  destination, passed through
- `rf_re_o`  out  1  RF read enable
- `rf_raddr_o`  out  RegAddrW  RF read address
- `rf_rdata_i`  in  XLEN  RF data, valid the cycle after `rf_re_o`
- `wb_valid_i`  in  1  writeback to RF this cycle
- `wb_addr_i`  in  RegAddrW  writeback index
- `wb_data_i`  in  XLEN  writeback data
- `alu_valid_o`  out  1  operands ready for ALU
- `alu_ready_i`  in  1  ALU consumes
- `alu_op_o`  out  `alu_op_t`  latched op
- `operand_o`  out  `[NumInPort-1:0][XLEN-1:0]`  collected operands
- `alu_rd_o`  out  RegAddrW  latched destination

## Operation
- FSM states:
  - IDLE: `req_ready_o`=1. On `req_valid_i`, latch the request and go to READ with slot counter k=0.
  - READ: one cycle per slot k. Then go to DRAIN.
  - DRAIN: one cycle; capture the last slot's data. Then go to ISSUE.
  - ISSUE: `alu_valid_o`=1. On `alu_ready_i`, go to IDLE.
- READ slot k:
  - Assert `rf_re_o`=1 with `rf_raddr_o`=rs[k].
  - Exception: rs[k]==0 or (k==NumInPort-1 and use_imm) gives `rf_re_o`=0. Operand k is then 0 or imm respectively.
  - In the same cycle, capture `rf_rdata_i` for slot k-1 if that slot issued a read.
- Every slot occupies its cycle whether or not it reads, so latency is fixed.
- `req_ready_o`=1 only in IDLE; no overlap with an in-flight instruction.
- `alu_op_o`, `operand_o` and `alu_rd_o` are held stable while `alu_valid_o`=1 and `alu_ready_i`=0.
- `alu_valid_o` never drops without a handshake, except on reset.
- The RF is read-before-write: a same-cycle write is not visible in the read data. The collector corrects this only when the bypass is compiled in.
- Reset:
  - FSM goes to IDLE.
  - `req_ready_o`, `rf_re_o` and `alu_valid_o` are 0 while `rst_i`=1.
  - `rf_raddr_o`, `alu_op_o`, `operand_o` and `alu_rd_o` reset to 0.
  - `req_ready_o`=1 the first cycle after `rst_i` falls.
  - Reset mid-instruction discards it; no `alu_valid_o` results.

## Timing
- Handshake at cycle T (IDLE, `req_valid_i`&`req_ready_o`).
- Slot k read at T+1+k; its data is captured at the end of T+2+k.
- `alu_valid_o` first high at T+NumInPort+2 (T+4 for 2 operands).
- With `alu_ready_i`=1, the handshake is at T+NumInPort+2 and `req_ready_o`=1 at T+NumInPort+3.
- Throughput: one instruction per NumInPort+3 cycles.

## Configuration
- `ALU_OC_BYPASS_EN` defined: a `wb_valid_i` with `wb_addr_i`==rs[k]!=0 (operand k not imm) updates operand k to `wb_data_i`.
  - Applies in any cycle from slot k's read cycle through the ISSUE handshake cycle, inclusive.
  - A bypass in the capture cycle wins over `rf_rdata_i`.
  - During ISSUE, `operand_o` may change only via this bypass.
- `ALU_OC_BYPASS_EN` undefined: `wb_*` ports are present but ignored. Operands are exactly RF data, 0 or imm.

## Test plan
- Read path: rs={3,7}, RF x3=0x11, x7=0x22, `alu_ready_i`=1.
  - `rf_re_o` at T+1 (addr 3) and T+2 (addr 7).
  - `alu_valid_o` at T+4 with operand={0x22,0x11} (index 1 first).
  - `req_ready_o` at T+5.
- x0 and immediate: rs={0,9}, use_imm=1, imm=0xFFFF_FFF0.
  - `rf_re_o` never asserted.
  - operand={0xFFFF_FFF0,0}, still valid at T+4.
- Backpressure: `alu_ready_i`=0 for 5 cycles after valid.
  - Outputs are stable for all 5 cycles; `req_ready_o`=0 and a new `req_valid_i` is ignored.
  - The handshake happens on the first `alu_ready_i`=1 cycle.
- Bypass (macro defined): wb x7=0x99 in the same cycle as the x7 read.
  - operand[1]=0x99.
  - Macro undefined: operand[1]=old RF value 0x22.
- Bypass during ISSUE (macro defined): wb x3=0x55 while stalled.
  - operand[0] becomes 0x55 the next cycle; `alu_valid_o` stays 1.
- Reset at T+2 of an instruction: no `alu_valid_o`; `rf_re_o`=0 during reset; `req_ready_o`=1 the cycle after `rst_i` deasserts.
